// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo constants: result/tag widths, "no station" / "no value"
// encodings, functional-unit count and the round-robin pointer helper.
package tomasulo_pkg;

    localparam int DATA_W = 16;
    localparam int QI_W   = 3;
    localparam int N_UF   = 3;
    localparam int PTR_W  = 2;

    localparam logic [QI_W-1:0]   QI_SEM_VALOR   = 3'b000;
    localparam logic [DATA_W-1:0] DATA_SEM_VALOR = 16'b1111_1111_1111_0000;

    // Next round-robin start position after unit k wins: (k + 1) mod 3.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] k);
        return (k == 2'd2) ? 2'd0 : k + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter_3.sv
// Combinational 3-way round-robin arbiter: picks the first requester found
// when searching from rr_ptr_i upward with wrap. Output is one-hot or zero.
module rr_arbiter_3
    import tomasulo_pkg::*;
(
    input  logic [N_UF-1:0]  request_i,
    input  logic [PTR_W-1:0] rr_ptr_i,
    output logic [N_UF-1:0]  grant_o
);

    logic [2*N_UF-1:0] req_dbl;
    logic [2*N_UF-1:0] pick_dbl;
    logic [N_UF-1:0]   req_rot;
    logic [N_UF-1:0]   pick_rot;

    // Rotate requests so rr_ptr is bit 0, take the lowest set bit, rotate back.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        req_dbl  = {request_i, request_i} >> rr_ptr_i;
        req_rot  = req_dbl[N_UF-1:0];
        pick_rot = req_rot & (~req_rot + 3'd1);
        pick_dbl = {pick_rot, pick_rot} << rr_ptr_i;
        grant_o  = pick_dbl[2*N_UF-1:N_UF];
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// Common Data Bus broadcaster: one holding slot per functional unit, a
// round-robin grant among occupied slots, and a registered one-cycle CDB
// broadcast of the winner. A slot may be released and reloaded on one edge.
module cdb_broadcaster #(
    parameter int                 DATA_W         = tomasulo_pkg::DATA_W,
    parameter int                 QI_W           = tomasulo_pkg::QI_W,
    parameter logic [QI_W-1:0]    QI_SEM_VALOR   = tomasulo_pkg::QI_SEM_VALOR,
    parameter logic [DATA_W-1:0]  DATA_SEM_VALOR = tomasulo_pkg::DATA_SEM_VALOR
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [2:0]        Valid_in,
    input  logic [QI_W-1:0]   Qi_in0,
    input  logic [QI_W-1:0]   Qi_in1,
    input  logic [QI_W-1:0]   Qi_in2,
    input  logic [DATA_W-1:0] Data_in0,
    input  logic [DATA_W-1:0] Data_in1,
    input  logic [DATA_W-1:0] Data_in2,
    output logic [2:0]        Ready_out,
    output logic              CDB_valid,
    output logic [QI_W-1:0]   Qi_CDB,
    output logic [DATA_W-1:0] Qi_CDB_data,
    output logic [1:0]        Pending
);

    import tomasulo_pkg::N_UF;
    import tomasulo_pkg::PTR_W;
    import tomasulo_pkg::next_ptr;

    logic [N_UF-1:0]   slot_valid_q, slot_valid_d;
    logic [QI_W-1:0]   slot_tag_q  [N_UF];
    logic [QI_W-1:0]   slot_tag_d  [N_UF];
    logic [DATA_W-1:0] slot_data_q [N_UF];
    logic [DATA_W-1:0] slot_data_d [N_UF];
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [QI_W-1:0]   cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [1:0]        pending_q, pending_d;

    logic [QI_W-1:0]   in_tag  [N_UF];
    logic [DATA_W-1:0] in_data [N_UF];
    logic [N_UF-1:0]   grant;
    logic [N_UF-1:0]   accept;

    assign in_tag[0]  = Qi_in0;
    assign in_tag[1]  = Qi_in1;
    assign in_tag[2]  = Qi_in2;
    assign in_data[0] = Data_in0;
    assign in_data[1] = Data_in1;
    assign in_data[2] = Data_in2;

    rr_arbiter_3 u_arb (
        .request_i (slot_valid_q),
        .rr_ptr_i  (rr_ptr_q),
        .grant_o   (grant)
    );

    // A slot can take a new result if empty or being drained on this edge.
    assign Ready_out = ~slot_valid_q | grant;

    // Handshake completes on Valid && Ready; a null tag is swallowed unstored.
    always_comb begin
        accept = '0;
        for (int k = 0; k < N_UF; k++) begin
            accept[k] = Valid_in[k] & Ready_out[k] & (in_tag[k] != QI_SEM_VALOR);
        end
    end

    // Slot update: a load wins over a release so same-edge reload keeps the slot full.
    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_tag_d   = slot_tag_q;
        slot_data_d  = slot_data_q;
        for (int k = 0; k < N_UF; k++) begin
            if (accept[k]) begin
                slot_valid_d[k] = 1'b1;
                slot_tag_d[k]   = in_tag[k];
                slot_data_d[k]  = in_data[k];
            end else if (grant[k]) begin
                slot_valid_d[k] = 1'b0;
            end
        end
        pending_d = 2'(slot_valid_d[0]) + 2'(slot_valid_d[1]) + 2'(slot_valid_d[2]);
    end

    // Broadcast the granted slot next cycle and advance the pointer past it.
    always_comb begin
        cdb_valid_d = |grant;
        cdb_tag_d   = QI_SEM_VALOR;
        cdb_data_d  = DATA_SEM_VALOR;
        rr_ptr_d    = rr_ptr_q;
        for (int k = 0; k < N_UF; k++) begin
            if (grant[k]) begin
                cdb_tag_d  = slot_tag_q[k];
                cdb_data_d = slot_data_q[k];
                rr_ptr_d   = next_ptr(PTR_W'(k));
            end
        end
    end

    // State registers: slots, pointer, CDB outputs and occupancy count.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            slot_valid_q <= '0;
            // NOTE: slot payloads are reset too; they are only three entries and this keeps them deterministic.
            for (int k = 0; k < N_UF; k++) begin
                slot_tag_q[k]  <= QI_SEM_VALOR;
                slot_data_q[k] <= DATA_SEM_VALOR;
            end
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= QI_SEM_VALOR;
            cdb_data_q  <= DATA_SEM_VALOR;
            pending_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            slot_valid_q <= slot_valid_d;
            slot_tag_q   <= slot_tag_d;
            slot_data_q  <= slot_data_d;
            rr_ptr_q     <= rr_ptr_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_data_q   <= cdb_data_d;
            pending_q    <= pending_d;
        end
    end

    assign CDB_valid   = cdb_valid_q;
    assign Qi_CDB      = cdb_tag_q;
    assign Qi_CDB_data = cdb_data_q;
    assign Pending     = pending_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Self-checking bench for cdb_broadcaster: directed vector table, hand-written
// fairness / reset sequences, and random traffic against a slot-level model.
module tb_cdb_broadcaster;

    localparam logic [15:0] DSEM = 16'hFFF0;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [2:0]  Valid_in;
    logic [2:0]  Qi_in0, Qi_in1, Qi_in2;
    logic [15:0] Data_in0, Data_in1, Data_in2;
    logic [2:0]  Ready_out;
    logic        CDB_valid;
    logic [2:0]  Qi_CDB;
    logic [15:0] Qi_CDB_data;
    logic [1:0]  Pending;

    cdb_broadcaster dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Valid_in    (Valid_in),
        .Qi_in0      (Qi_in0),
        .Qi_in1      (Qi_in1),
        .Qi_in2      (Qi_in2),
        .Data_in0    (Data_in0),
        .Data_in1    (Data_in1),
        .Data_in2    (Data_in2),
        .Ready_out   (Ready_out),
        .CDB_valid   (CDB_valid),
        .Qi_CDB      (Qi_CDB),
        .Qi_CDB_data (Qi_CDB_data),
        .Pending     (Pending)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: one held result per unit ----------------
    bit          m_occ  [3];
    logic [2:0]  m_tag  [3];
    logic [15:0] m_data [3];
    int          m_ptr;
    logic        m_cdb_v;
    logic [2:0]  m_cdb_tag;
    logic [15:0] m_cdb_data;
    int          m_pending;

    function automatic int m_grant();
        for (int i = 0; i < 3; i++) begin
            int idx = (m_ptr + i) % 3;
            if (m_occ[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [2:0] m_ready();
        int g = m_grant();
        logic [2:0] r;
        for (int k = 0; k < 3; k++) r[k] = !m_occ[k] || (k == g);
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) m_occ[k] = 0;
        m_ptr = 0; m_cdb_v = 0; m_cdb_tag = 3'b000; m_cdb_data = DSEM; m_pending = 0;
    endtask

    task automatic model_edge();
        logic [2:0]  t [3];
        logic [15:0] d [3];
        int g = m_grant();
        t[0] = Qi_in0; t[1] = Qi_in1; t[2] = Qi_in2;
        d[0] = Data_in0; d[1] = Data_in1; d[2] = Data_in2;
        if (g >= 0) begin
            m_cdb_v = 1; m_cdb_tag = m_tag[g]; m_cdb_data = m_data[g];
            m_occ[g] = 0; m_ptr = (g + 1) % 3;
        end else begin
            m_cdb_v = 0; m_cdb_tag = 3'b000; m_cdb_data = DSEM;
        end
        for (int k = 0; k < 3; k++) begin
            if (Valid_in[k] && !m_occ[k] && t[k] != 3'b000) begin
                m_occ[k] = 1; m_tag[k] = t[k]; m_data[k] = d[k];
            end
        end
        m_pending = 0;
        for (int k = 0; k < 3; k++) m_pending += int'(m_occ[k]);
    endtask

    // One clock against the model: Ready before the edge, registers after it.
    task automatic cycle(input string nm);
        check({nm, " ready"}, Ready_out, m_ready());
        @(posedge Clock); #1;
        model_edge();
        check({nm, " cdb_valid"}, CDB_valid, m_cdb_v);
        check({nm, " qi_cdb"}, Qi_CDB, m_cdb_tag);
        check({nm, " cdb_data"}, Qi_CDB_data, m_cdb_data);
        check({nm, " pending"}, Pending, m_pending);
    endtask

    task automatic set_in(input logic [2:0] v, input logic [2:0] q0, q1, q2,
                          input logic [15:0] d0, d1, d2);
        Valid_in = v; Qi_in0 = q0; Qi_in1 = q1; Qi_in2 = q2;
        Data_in0 = d0; Data_in1 = d1; Data_in2 = d2;
    endtask

    // Reset pulse over one edge, released #1 after a rising edge.
    task automatic pulse_reset();
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [2:0]  valid;
        logic [2:0]  q0, q1, q2;
        logic [15:0] d0, d1, d2;
        logic [2:0]  exp_ready;
        logic        exp_v;
        logic [2:0]  exp_tag;
        logic [15:0] exp_data;
        logic [1:0]  exp_pend;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input logic [2:0] v, input logic [2:0] q0, q1, q2,
                           input logic [15:0] d0, d1, d2, input logic [2:0] er,
                           input logic ev, input logic [2:0] et, input logic [15:0] ed,
                           input logic [1:0] ep);
        vec_t r;
        r.valid = v; r.q0 = q0; r.q1 = q1; r.q2 = q2;
        r.d0 = d0; r.d1 = d1; r.d2 = d2;
        r.exp_ready = er; r.exp_v = ev; r.exp_tag = et; r.exp_data = ed; r.exp_pend = ep;
        vq.push_back(r);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int alt_tag [8];
        int found_at;

        // Three simultaneous results, then drain in order 0,1,2.
        add_vec(3'b111, 3'b001, 3'b011, 3'b101, 16'h0011, 16'h0022, 16'h0033, 3'b111, 0, 3'b000, DSEM, 2'd3);
        add_vec(3'b000, 0, 0, 0, 0, 0, 0, 3'b001, 1, 3'b001, 16'h0011, 2'd2);
        add_vec(3'b000, 0, 0, 0, 0, 0, 0, 3'b011, 1, 3'b011, 16'h0022, 2'd1);
        add_vec(3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 1, 3'b101, 16'h0033, 2'd0);
        add_vec(3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 0, 3'b000, DSEM, 2'd0);
        // Single result: no bypass, visible one edge after acceptance.
        add_vec(3'b001, 3'b010, 0, 0, 16'h0005, 0, 0, 3'b111, 0, 3'b000, DSEM, 2'd1);
        add_vec(3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 1, 3'b010, 16'h0005, 2'd0);
        add_vec(3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 0, 3'b000, DSEM, 2'd0);
        // Null tag is accepted and dropped.
        add_vec(3'b010, 0, 3'b000, 0, 0, 16'h1234, 0, 3'b111, 0, 3'b000, DSEM, 2'd0);
        // Five idle cycles.
        for (int i = 0; i < 5; i++)
            add_vec(3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 0, 3'b000, DSEM, 2'd0);

        // ---- reset state ----
        set_in(3'b000, 0, 0, 0, 0, 0, 0);
        Reset = 1'b1;
        #1;
        check("rst cdb_valid", CDB_valid, 1'b0);
        check("rst qi_cdb", Qi_CDB, 3'b000);
        check("rst cdb_data", Qi_CDB_data, DSEM);
        check("rst pending", Pending, 2'd0);
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        model_reset();
        check("post_rst ready", Ready_out, 3'b111);

        // ---- table ----
        for (int i = 0; i < vq.size(); i++) begin
            set_in(vq[i].valid, vq[i].q0, vq[i].q1, vq[i].q2, vq[i].d0, vq[i].d1, vq[i].d2);
            check($sformatf("vec%0d ready", i), Ready_out, vq[i].exp_ready);
            @(posedge Clock); #1;
            check($sformatf("vec%0d cdb_valid", i), CDB_valid, vq[i].exp_v);
            check($sformatf("vec%0d qi_cdb", i), Qi_CDB, vq[i].exp_tag);
            check($sformatf("vec%0d cdb_data", i), Qi_CDB_data, vq[i].exp_data);
            check($sformatf("vec%0d pending", i), Pending, vq[i].exp_pend);
        end

        // ---- reset in the middle of traffic ----
        set_in(3'b000, 0, 0, 0, 0, 0, 0);
        pulse_reset();
        set_in(3'b111, 3'b001, 3'b011, 3'b101, 16'h0A01, 16'h0A02, 16'h0A03);
        cycle("mid_fill");
        set_in(3'b000, 0, 0, 0, 0, 0, 0);
        cycle("mid_drain");
        check("mid pre_rst cdb_valid", CDB_valid, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        check("mid rst cdb_valid", CDB_valid, 1'b0);
        check("mid rst qi_cdb", Qi_CDB, 3'b000);
        check("mid rst cdb_data", Qi_CDB_data, DSEM);
        check("mid rst pending", Pending, 2'd0);
        check("mid rst ready", Ready_out, 3'b111);
        @(posedge Clock); #1;
        Reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) cycle("mid_after");

        // ---- fairness: units 0 and 2 present continuously ----
        pulse_reset();
        set_in(3'b101, 3'b001, 3'b000, 3'b101, 16'h00A0, 16'h0000, 16'h00B0);
        for (int i = 0; i < 8; i++) begin
            cycle("fair");
            alt_tag[i] = int'(Qi_CDB);
        end
        for (int i = 1; i < 8; i++)
            check($sformatf("fair_alt%0d", i), alt_tag[i], (i % 2 == 1) ? 1 : 5);
        // Unit 1 joins for one handshake and must be broadcast within 3 cycles.
        set_in(3'b111, 3'b001, 3'b011, 3'b101, 16'h00A0, 16'h00C0, 16'h00B0);
        cycle("fair_u1_acc");
        set_in(3'b101, 3'b001, 3'b000, 3'b101, 16'h00A0, 16'h0000, 16'h00B0);
        found_at = 0;
        for (int j = 1; j <= 5; j++) begin
            cycle("fair_u1");
            if (found_at == 0 && CDB_valid && Qi_CDB == 3'b011) found_at = j;
        end
        check("fair_u1_within3", (found_at >= 1 && found_at <= 3), 1'b1);

        // ---- randomized traffic against the model ----
        set_in(3'b000, 0, 0, 0, 0, 0, 0);
        pulse_reset();
        for (int i = 0; i < 400; i++) begin
            set_in(3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   16'($urandom), 16'($urandom), 16'($urandom));
            cycle("rand");
        end
        set_in(3'b000, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
